// File: rtl/fft_cooley_tukey_bitrev_deserializer.sv
// Serial-to-parallel front end for the FFT: packs N_SAMPLES real samples per frame, bit-reversed by default.
// Latency: send_val rises the cycle after the last sample of a frame is accepted.
// Backpressure: two ping-pong banks; recv_rdy drops only when both banks hold unsent frames.
module fft_cooley_tukey_bitrev_deserializer #(
  parameter int BIT_WIDTH   = 32,
  parameter int N_SAMPLES   = 8,
  parameter bit BIT_REVERSE = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [BIT_WIDTH-1:0]                 recv_msg,
  input  logic                                 recv_val,
  output logic                                 recv_rdy,
  output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0]  send_msg_real,
  output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0]  send_msg_imag,
  output logic                                 send_val,
  input  logic                                 send_rdy
);

  localparam int               CNT_W    = $clog2(N_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES - 1);

  // A bank is FILLING when it is EMPTY and wr_bank points at it.
  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_t;

  bank_state_t          bank_q [2];
  bank_state_t          bank_d [2];
  logic                 wr_bank_q;
  logic                 rd_bank_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     wr_idx;
  logic [BIT_WIDTH-1:0] frame_q [2][N_SAMPLES];
  logic                 recv_fire;
  logic                 send_fire;
  logic                 last_sample;

  function automatic logic [CNT_W-1:0] bitrev(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    r = '0;
    for (int i = 0; i < CNT_W; i++) begin
      r[i] = v[CNT_W-1-i];
    end
    return r;
  endfunction

  // Handshake signals come from registered bank state only, never from send_rdy.
  assign recv_rdy    = (bank_q[wr_bank_q] == BANK_EMPTY);
  assign send_val    = (bank_q[rd_bank_q] == BANK_FULL);
  assign recv_fire   = recv_val & recv_rdy;
  assign send_fire   = send_val & send_rdy;
  assign last_sample = (cnt_q == CNT_LAST);
  assign wr_idx      = BIT_REVERSE ? bitrev(cnt_q) : cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_q[0] <= BANK_EMPTY;
      bank_q[1] <= BANK_EMPTY;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
    end
  end

  // A filling bank is never full and a draining bank always is, so the two updates never collide.
  always_comb begin
    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    if (recv_fire && last_sample) begin
      bank_d[wr_bank_q] = BANK_FULL;
    end
    if (send_fire) begin
      bank_d[rd_bank_q] = BANK_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      if (recv_fire) begin
        if (last_sample) begin
          cnt_q     <= '0;
          wr_bank_q <= ~wr_bank_q;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
      if (send_fire) begin
        rd_bank_q <= ~rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N_SAMPLES; i++) begin
          frame_q[b][i] <= '0;
        end
      end
    end else if (recv_fire) begin
      frame_q[wr_bank_q][wr_idx] <= recv_msg;
    end
  end

  always_comb begin
    send_msg_imag = '0;
    for (int i = 0; i < N_SAMPLES; i++) begin
      send_msg_real[i] = frame_q[rd_bank_q][i];
    end
  end

endmodule

// File: tb/tb_fft_cooley_tukey_bitrev_deserializer.sv
// Directed bench for the bit-reversing deserializer; a negedge monitor scoreboards every sent frame.
module tb_fft_cooley_tukey_bitrev_deserializer;

  localparam int W = 32;
  localparam int N = 8;

  logic                 clk;
  logic                 reset;
  logic [W-1:0]         recv_msg;
  logic                 recv_val;
  logic                 send_rdy;
  logic                 recv_rdy;
  logic                 send_val;
  logic [N-1:0][W-1:0]  dut_real;
  logic [N-1:0][W-1:0]  dut_imag;
  logic                 lin_recv_rdy;
  logic                 lin_send_val;
  logic [N-1:0][W-1:0]  lin_real;
  logic [N-1:0][W-1:0]  lin_imag;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int frames_seen = 0;
  int acc_cnt = 0;
  int rev_tab [N] = '{0, 4, 2, 6, 1, 5, 3, 7};
  logic [N*W-1:0] acc_br;
  logic [N*W-1:0] acc_lin;
  logic [N*W-1:0] exp_br [$];
  logic [N*W-1:0] exp_lin [$];

  fft_cooley_tukey_bitrev_deserializer #(.BIT_WIDTH(W), .N_SAMPLES(N), .BIT_REVERSE(1'b1)) dut (
    .clk(clk), .reset(reset), .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(recv_rdy),
    .send_msg_real(dut_real), .send_msg_imag(dut_imag), .send_val(send_val), .send_rdy(send_rdy)
  );

  fft_cooley_tukey_bitrev_deserializer #(.BIT_WIDTH(W), .N_SAMPLES(N), .BIT_REVERSE(1'b0)) dut_lin (
    .clk(clk), .reset(reset), .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(lin_recv_rdy),
    .send_msg_real(lin_real), .send_msg_imag(lin_imag), .send_val(lin_send_val), .send_rdy(send_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d);
    logic ok;
    ok = 1'b0;
    recv_val = 1'b1;
    recv_msg = d;
    for (int t = 0; t < 200; t++) begin
      ok = recv_rdy;
      step();
      if (ok) break;
    end
    if (!ok) chk("push_timeout", 0, 1);
    recv_val = 1'b0;
  endtask

  // Scoreboard: model frames from accepted samples, compare on every send fire.
  always @(negedge clk) begin
    if (!reset) begin
      acc_cnt = 0;
      exp_br.delete();
      exp_lin.delete();
    end else begin
      if (send_val && send_rdy) begin
        frames_seen++;
        if (exp_br.size() == 0) begin
          chk("sb_unexpected_frame", 1, 0);
        end else begin
          chk("sb_frame_br", dut_real, exp_br.pop_front());
          chk("sb_frame_lin", lin_real, exp_lin.pop_front());
          chk("sb_imag", dut_imag, 0);
        end
      end
      if (recv_val && recv_rdy) begin
        acc_br[rev_tab[acc_cnt]*W +: W] = recv_msg;
        acc_lin[acc_cnt*W +: W] = recv_msg;
        acc_cnt++;
        if (acc_cnt == N) begin
          exp_br.push_back(acc_br);
          exp_lin.push_back(acc_lin);
          acc_cnt = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    chk("watchdog", 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int start_cyc;
    int n_acc;
    int guard;
    logic acc;

    reset = 1'b0;
    recv_val = 1'b0;
    recv_msg = '0;
    send_rdy = 1'b0;
    step();
    step();
    chk("rst_send_val", send_val, 0);
    chk("rst_real", dut_real, 0);
    chk("rst_imag", dut_imag, 0);
    reset = 1'b1;
    step();
    chk("rst_recv_rdy", recv_rdy, 1);

    // Samples 0..7, bit-reversed and linear banks side by side.
    send_rdy = 1'b1;
    for (int k = 0; k < N - 1; k++) push(W'(k));
    chk("t1_val_before_last", send_val, 0);
    push(W'(7));
    chk("t1_send_val", send_val, 1);
    for (int i = 0; i < N; i++) chk("t1_real_elem", dut_real[i], rev_tab[i]);
    chk("t1_imag", dut_imag, 0);
    for (int i = 0; i < N; i++) chk("t2_lin_elem", lin_real[i], i);
    step();
    chk("t1_val_drained", send_val, 0);

    // Both banks fill with send_rdy low.
    send_rdy = 1'b0;
    for (int k = 0; k < 2 * N; k++) push(W'(100 + k));
    chk("t3_recv_rdy_low", recv_rdy, 0);
    chk("t3_send_val", send_val, 1);
    recv_val = 1'b1;
    recv_msg = 32'hDEAD_BEEF;
    step();
    step();
    step();
    for (int i = 0; i < N; i++) chk("t3_frame_a_stable", dut_real[i], 100 + rev_tab[i]);
    chk("t3_still_blocked", recv_rdy, 0);
    recv_val = 1'b0;
    send_rdy = 1'b1;
    step();
    send_rdy = 1'b0;
    chk("t3_after_pulse1_val", send_val, 1);
    chk("t3_after_pulse1_rdy", recv_rdy, 1);
    for (int i = 0; i < N; i++) chk("t3_frame_b", dut_real[i], 108 + rev_tab[i]);
    send_rdy = 1'b1;
    step();
    send_rdy = 1'b0;
    chk("t3_after_pulse2_val", send_val, 0);
    chk("t3_after_pulse2_rdy", recv_rdy, 1);

    // Frame completion and send on the same edge, 1 sample/cycle.
    base = frames_seen;
    start_cyc = cyc;
    for (int k = 0; k < 5 * N; k++) begin
      send_rdy = ((k % N) == N - 1) && (k >= 2 * N - 1);
      push(W'(200 + k));
    end
    chk("t4_cycles", cyc - start_cyc, 5 * N);
    send_rdy = 1'b1;
    step();
    step();
    chk("t4_frames", frames_seen - base, 5);
    chk("t4_queue_empty", exp_br.size(), 0);

    // Async reset with one full frame and a partial one in flight.
    send_rdy = 1'b0;
    for (int k = 0; k < N + 5; k++) push(W'(400 + k));
    chk("t5_pre_val", send_val, 1);
    #3;
    reset = 1'b0;
    #1;
    chk("t5_async_val", send_val, 0);
    chk("t5_async_real", dut_real, 0);
    chk("t5_async_lin", lin_real, 0);
    chk("t5_async_rdy", recv_rdy, 1);
    step();
    step();
    reset = 1'b1;
    send_rdy = 1'b1;
    for (int k = 0; k < N - 1; k++) push(W'(300 + k));
    chk("t5_no_residue_val", send_val, 0);
    push(W'(307));
    chk("t5_clean_val", send_val, 1);
    for (int i = 0; i < N; i++) chk("t5_clean_elem", dut_real[i], 300 + rev_tab[i]);
    step();

    // Random valid/ready gaps over 100 frames.
    base = frames_seen;
    n_acc = 0;
    guard = 0;
    while (n_acc < 100 * N && guard < 20000) begin
      recv_val = ($urandom_range(0, 3) != 0);
      recv_msg = $urandom;
      send_rdy = ($urandom_range(0, 2) != 0);
      acc = recv_val && recv_rdy;
      step();
      if (acc) n_acc++;
      guard++;
    end
    chk("t6_accept_all", n_acc, 100 * N);
    recv_val = 1'b0;
    send_rdy = 1'b1;
    repeat (5) step();
    chk("t6_frames", frames_seen - base, 100);
    chk("t6_queue_empty", exp_br.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
